// File: rtl/mem_io_pkg.sv
// Shared decode constants, region encoding and stall-state type for the memory/I-O responder.
package mem_io_pkg;

    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_CLK_ADDR  = 32'h0003_0004;

    typedef enum logic [1:0] {
        REGION_RAM_LO = 2'b00,
        REGION_RAM_HI = 2'b01,
        REGION_NONE   = 2'b10,
        REGION_IO     = 2'b11
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        STALL_RX,
        STALL_TX,
        STOPPED
    } stall_state_t;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with 2^AW entries; push is ignored when full and pop when empty.
module byte_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = level[AW];
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU byte-bus responder: RAM, UART FIFOs, cycle counter and program stop, with rdy-based stalls.
// Define MEM_IO_CYCLE_COUNTER_EN to build the cycle counter and its snapshot register.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        cpu_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop
);

    stall_state_t      state, next_state;
    region_t           region;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram [2**RAM_AW];
    logic              ram_we;
    logic              is_uart, is_stop;
    logic [7:0]        rdata_next, tx_hold, hold_next, tx_push_byte, counter_byte;
    logic              stop_pend, stop_next;
    logic              rx_pop, rx_full, rx_empty, tx_push, tx_full, tx_empty;
    logic [7:0]        rx_head;
    logic              unused_bus;

    assign region     = region_t'(bus_a[17:16]);
    assign ram_addr   = bus_a[RAM_AW-1:0];
    assign is_uart    = (bus_a[2:0] == IO_UART_ADDR[2:0]);
    assign is_stop    = (bus_a[2:0] == IO_CLK_ADDR[2:0]);
    assign unused_bus = ^bus_a[31:18];
    assign rx_ready   = !rx_full;
    assign tx_valid   = !tx_empty;

    byte_fifo #(.AW(FIFO_AW)) rx_fifo (
        .clk(clk), .rst(rst), .push(rx_valid && rx_ready), .pop(rx_pop),
        .din(rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    byte_fifo #(.AW(FIFO_AW)) tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_valid && tx_ready),
        .din(tx_push_byte), .head(tx_data), .full(tx_full), .empty(tx_empty)
    );

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt, cycle_snap;
    logic        snap_take;

    // Reading byte 0 freezes the whole count so bytes 1..3 are coherent with it.
    assign snap_take = (state == IDLE) && (region == REGION_IO) && !bus_wr && is_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            cycle_snap <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (snap_take) cycle_snap <= cycle_cnt;
        end
    end

    always_comb begin
        counter_byte = 8'h00;
        if (bus_a[2]) begin
            if (bus_a[1:0] == 2'd0) counter_byte = byte_of(cycle_cnt, 2'd0);
            else                    counter_byte = byte_of(cycle_snap, bus_a[1:0]);
        end
    end
`else
    assign counter_byte = 8'h00;
`endif

    always_comb begin
        next_state   = state;
        rdata_next   = bus_rdata;
        hold_next    = tx_hold;
        stop_next    = stop_pend;
        tx_push_byte = tx_hold;
        tx_push      = 1'b0;
        rx_pop       = 1'b0;
        ram_we       = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (region)
                    REGION_RAM_LO, REGION_RAM_HI: begin
                        if (bus_wr) ram_we = 1'b1;
                        else        rdata_next = ram[ram_addr];
                    end
                    REGION_NONE: begin
                        if (!bus_wr) rdata_next = 8'h00;
                    end
                    REGION_IO: begin
                        if (bus_wr) begin
                            // The stop write enqueues a NUL marker; plain UART NULs are dropped.
                            if ((is_uart && bus_wdata != 8'h00) || is_stop) begin
                                tx_push_byte = is_stop ? 8'h00 : bus_wdata;
                                if (tx_full) begin
                                    hold_next  = tx_push_byte;
                                    stop_next  = is_stop;
                                    next_state = STALL_TX;
                                end else begin
                                    tx_push = 1'b1;
                                    if (is_stop) next_state = STOPPED;
                                end
                            end
                        end else if (is_uart) begin
                            if (rx_empty) begin
                                next_state = STALL_RX;
                            end else begin
                                rx_pop     = 1'b1;
                                rdata_next = rx_head;
                            end
                        end else begin
                            rdata_next = counter_byte;
                        end
                    end
                endcase
            end
            STALL_RX: begin
                if (!rx_empty) begin
                    rx_pop     = 1'b1;
                    rdata_next = rx_head;
                    next_state = IDLE;
                end
            end
            STALL_TX: begin
                if (!tx_full) begin
                    tx_push    = 1'b1;
                    next_state = stop_pend ? STOPPED : IDLE;
                end
            end
            STOPPED: begin
                next_state = STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_rdata <= 8'h00;
            cpu_rdy   <= 1'b1;
            tx_hold   <= 8'h00;
            stop_pend <= 1'b0;
            prog_stop <= 1'b0;
        end else begin
            state     <= next_state;
            bus_rdata <= rdata_next;
            cpu_rdy   <= (next_state == IDLE);
            tx_hold   <= hold_next;
            stop_pend <= stop_next;
            prog_stop <= (next_state == STOPPED);
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= bus_wdata;
    end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Bus responder on the CPU's byte-wide memory port: a 128 KiB byte RAM plus the memory-mapped I/O window at 0x30000 (UART byte in/out, cycle counter, program stop). It is the slave end of the interface the CPU core initiates on, and it drives the CPU's `rdy` input to pause the core when an I/O access cannot complete, for example on an empty input FIFO or a full output FIFO. It sits between the CPU core and the UART rx/tx shims in the top level.

## Interface
- `RAM_AW`, 17: RAM byte-address width (2^17 bytes).
- `FIFO_AW`, 4: log2 depth of each UART FIFO.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high. One clock domain.
- `bus_a`  in  32: CPU address (only [17:0] decoded).
- `bus_wr`  in  1: 1 = write, 0 = read.
- `bus_wdata`  in  8: CPU write byte.
- `bus_rdata`  out  8: registered read byte to CPU.
- `cpu_rdy`  out  1: registered; low pauses the CPU.
- `rx_data` / `rx_valid` / `rx_ready`: in 8 / in 1 / out 1. Byte stream from the UART receiver, valid/ready handshake.
- `tx_data` / `tx_valid` / `tx_ready`: out 8 / out 1 / in 1. Byte stream to the UART transmitter.
- `prog_stop`  out  1: sticky program-stop flag.

## Operation
- Reset values:
  - `bus_rdata`=0x00, `cpu_rdy`=1, `tx_valid`=0, `rx_ready`=1, `prog_stop`=0.
  - FIFOs are empty and the counter is 0.
  - The stall state is IDLE.
- Decode on `bus_a[17:16]`:
  - 00/01: RAM at `bus_a[16:0]`.
  - 10: unmapped. Reads return 0x00 and writes are dropped.
  - 11: I/O. `bus_a[2:0]`=0 is UART, 4..7 is the counter. Other I/O addresses read 0x00 and ignore writes.
- RAM read: `bus_rdata` <= ram[a]. RAM write: ram[a] <= `bus_wdata`.
- UART read (0x30000):
  - RX FIFO non-empty: pop the head into `bus_rdata`.
  - RX FIFO empty: enter STALL_RX.
- UART write (0x30000):
  - `bus_wdata`==0x00 is ignored.
  - Otherwise push to the TX FIFO. If the TX FIFO is full, latch the byte and enter STALL_TX.
- 0x30004 write: push 0x00 to the TX FIFO (stall if full, as above), then set `prog_stop`. `cpu_rdy` is held low permanently until `rst`.
- Counter reads:
  - A read of 0x30004 returns byte 0 of the live counter and snapshots all 32 bits.
  - Reads of 0x30005..7 return snapshot bytes 1..3.
- State machine:
  - IDLE -> STALL_RX on a UART read with the RX FIFO empty.
  - IDLE -> STALL_TX on a UART/stop write with the TX FIFO full.
  - STALL_RX -> IDLE on the first edge with the RX FIFO non-empty: pop the byte into `bus_rdata`.
  - STALL_TX -> IDLE on the first edge with the TX FIFO not full: push the latched byte.
  - IDLE -> STOPPED after the stop byte is pushed. STOPPED is terminal.
- Bus capture while stalled:
  - While not IDLE, the bus is not captured. `bus_a`/`bus_wr`/`bus_wdata` then hold the CPU's next transaction.
  - That transaction is captured at the first edge after returning to IDLE, exactly once.
- FIFOs:
  - `rx_ready` = !rx_full. `tx_valid` = !tx_empty.
  - A simultaneous push and pop on a non-empty, non-full FIFO changes neither level.
  - Pointers wrap modulo 2^FIFO_AW.

## Timing
- Read: address present before edge E, so `bus_rdata` is valid after E, and the CPU samples it at E+1 (2-cycle read as seen by the CPU).
- Write: takes effect at the capturing edge. There is no wait.
- Stall entry:
  - `cpu_rdy` drops after the capturing edge E, so CPU edge E+1 is frozen.
  - The CPU has already advanced at E, so the stalled transaction is not re-presented.
- Stall exit: `cpu_rdy` rises after the release edge R, and the CPU resumes at R+1.
- RX byte accepted at edge P while in STALL_RX: popped at P+1, `bus_rdata` valid after P+1.
- Counter: increments every clk while not in reset and wraps 0xFFFFFFFF -> 0. It keeps counting in STALL and STOPPED.
- Reset mid-stall: returns to IDLE. FIFO contents and any latched TX byte are discarded.

## Configuration
- `MEM_IO_CYCLE_COUNTER_EN` defined: counter and snapshot built, and 0x30004..7 read as above.
- `MEM_IO_CYCLE_COUNTER_EN` undefined: no counter flops. 0x30004..7 read 0x00, and the 0x30004 write still stops.

## Structure
- Package `mem_io_pkg` holds:
  - `IO_UART_ADDR`=0x30000 and `IO_CLK_ADDR`=0x30004.
  - The decode-region encoding.
  - The stall-state enum: IDLE, STALL_RX, STALL_TX, STOPPED.
- Sub-module `byte_fifo` (param `AW`; push/pop/full/empty/head) is instantiated twice, once for RX and once for TX.

## Test plan
- RAM write 0xA5 to 0x00123, then read 0x00123 -> `bus_rdata`=0xA5 one edge after capture; read of 0x20010 -> 0x00.
- UART read with RX empty -> `cpu_rdy`=0; inject 0x41 -> popped next edge, `bus_rdata`=0x41, `cpu_rdy`=1; the following bus transaction is captured exactly once.
- UART writes 0x48, 0x00, 0x69 -> TX stream is exactly 0x48, 0x69.
- Hold `tx_ready`=0, write 2^FIFO_AW+1 non-zero bytes -> stall on the last one; release `tx_ready` -> all bytes emitted in order, none lost or duplicated.
- Preload the counter near wrap (0xFFFFFFFE via force); read 0x30004..7 across the wrap -> all four bytes from one snapshot.
- Write 0x30004 -> tx emits 0x00, `prog_stop`=1, `cpu_rdy` held 0; assert `rst` mid-stall -> all outputs return to reset values.
